// File: rtl/ide_host_pio_if.sv
// IDE/ATA device-side bus between the PIO host engine (master) and a drive (slave).
interface ide_host_pio_if;
  logic [15:0] dd_in;
  logic [15:0] dd_out;
  logic        dd_oe;
  logic [2:0]  da;
  logic        cs1fx_;
  logic        cs3fx_;
  logic        dior_;
  logic        diow_;
  logic        iordy;
  logic        intrq;

  modport master (
    input  dd_in, iordy, intrq,
    output dd_out, dd_oe, da, cs1fx_, cs3fx_, dior_, diow_
  );

  modport slave (
    output dd_in, iordy, intrq,
    input  dd_out, dd_oe, da, cs1fx_, cs3fx_, dior_, diow_
  );
endinterface

// File: rtl/ide_host_pio.sv
// PIO-mode ATA host engine: one 16-bit task-file register read or write per request.
// Define IDE_HOST_IORDY_TMO_EN to force-terminate strobes stretched by IORDY (sets err).
//
// state     | meaning
// S_IDLE    | waiting for req, bus released
// S_SETUP   | da/cs driven, T1_CYC cycles before strobe
// S_STROBE  | DIOR-/DIOW- low, at least T2_CYC cycles, stretched by IORDY
// S_HOLD    | strobe high, address/data held T4_CYC cycles
// S_RECOVER | bus released, done in first cycle, TREC_CYC cycles
module ide_host_pio #(
  parameter int T1_CYC    = 2,
  parameter int T2_CYC    = 6,
  parameter int T4_CYC    = 1,
  parameter int TREC_CYC  = 4,
  parameter int IORDY_TMO = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_i,
  input  logic           we_i,
  input  logic           csel_i,
  input  logic [2:0]     addr_i,
  input  logic [15:0]    wdata_i,
  output logic [15:0]    rdata_o,
  output logic           done_o,
  output logic           busy_o,
  output logic           err_o,
  output logic           irq_o,
  ide_host_pio_if.master ide
);

  localparam int M_A  = (T1_CYC > T2_CYC) ? T1_CYC : T2_CYC;
  localparam int M_B  = (T4_CYC > TREC_CYC) ? T4_CYC : TREC_CYC;
  localparam int M_C  = (M_A > M_B) ? M_A : M_B;
  localparam int MAXC = (M_C > IORDY_TMO) ? M_C : IORDY_TMO;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          we_q, csel_q;
  logic [2:0]    addr_q;
  logic [15:0]   wdata_q;
  logic          iordy_m_q, iordy_s_q;
  logic          intrq_m_q, intrq_s_q;
  logic          accept, strobe_end, timeout, active;

`ifdef IDE_HOST_IORDY_TMO_EN
  localparam int EW = $clog2(IORDY_TMO + 1);
  logic [EW-1:0] ext_q, ext_d;
  logic          tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    accept     = 1'b0;
    strobe_end = 1'b0;
    timeout    = 1'b0;
`ifdef IDE_HOST_IORDY_TMO_EN
    ext_d      = ext_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          accept  = 1'b1;
          state_d = S_SETUP;
          cnt_d   = CW'(T1_CYC - 1);
`ifdef IDE_HOST_IORDY_TMO_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = CW'(T2_CYC - 1);
`ifdef IDE_HOST_IORDY_TMO_EN
          ext_d   = EW'(IORDY_TMO);
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        // cnt_q reaching zero marks the T2_CYC minimum; beyond it IORDY decides.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (iordy_s_q) begin
          strobe_end = 1'b1;
`ifdef IDE_HOST_IORDY_TMO_EN
        end else if (ext_q == '0) begin
          strobe_end = 1'b1;
          timeout    = 1'b1;
          tmo_d      = 1'b1;
        end else begin
          ext_d = ext_q - EW'(1);
`endif
        end
        if (strobe_end) begin
          state_d = S_HOLD;
          cnt_d   = CW'(T4_CYC - 1);
          if (!we_q) rdata_d = timeout ? 16'hFFFF : ide.dd_in;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_RECOVER;
          cnt_d   = CW'(TREC_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RECOVER: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      csel_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      iordy_m_q <= 1'b0;
      iordy_s_q <= 1'b0;
      intrq_m_q <= 1'b0;
      intrq_s_q <= 1'b0;
`ifdef IDE_HOST_IORDY_TMO_EN
      ext_q     <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      iordy_m_q <= ide.iordy;
      iordy_s_q <= iordy_m_q;
      intrq_m_q <= ide.intrq;
      intrq_s_q <= intrq_m_q;
`ifdef IDE_HOST_IORDY_TMO_EN
      ext_q     <= ext_d;
      tmo_q     <= tmo_d;
`endif
      if (accept) begin
        we_q    <= we_i;
        csel_q  <= csel_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  assign active     = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
  assign ide.da     = active ? addr_q : 3'd0;
  assign ide.cs1fx_ = !(active && !csel_q);
  assign ide.cs3fx_ = !(active && csel_q);
  assign ide.dior_  = !((state_q == S_STROBE) && !we_q);
  assign ide.diow_  = !((state_q == S_STROBE) && we_q);
  assign ide.dd_oe  = active && we_q;
  assign ide.dd_out = (active && we_q) ? wdata_q : 16'h0000;

  assign rdata_o = rdata_q;
  assign done_o  = (state_q == S_RECOVER) && (cnt_q == CW'(TREC_CYC - 1));
  assign busy_o  = (state_q != S_IDLE);
  assign irq_o   = intrq_s_q;

`ifdef IDE_HOST_IORDY_TMO_EN
  assign err_o = tmo_q && ((state_q == S_RECOVER) || (state_q == S_IDLE));
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ide_host_pio.sv
// Directed bench for ide_host_pio: table of single transfers plus hand-written corner sequences.
module tb_ide_host_pio;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, csel_i;
  logic [2:0]  addr_i;
  logic [15:0] wdata_i, rdata_o;
  logic        done_o, busy_o, err_o, irq_o;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_rdata;

  ide_host_pio_if ide ();

  ide_host_pio #(
    .T1_CYC(2), .T2_CYC(6), .T4_CYC(1), .TREC_CYC(4), .IORDY_TMO(4)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .csel_i(csel_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o),
    .busy_o(busy_o), .err_o(err_o), .irq_o(irq_o), .ide(ide)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        csel;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] dd_in;
    int          rise;
    int          exp_first;
    int          exp_last;
    int          exp_done;
    int          exp_idle;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  localparam logic [43:0] RST_PAT = {4'b1111, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'b0000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] out_pat();
    return {ide.dior_, ide.diow_, ide.cs1fx_, ide.cs3fx_, ide.da, ide.dd_out, ide.dd_oe,
            rdata_o, done_o, busy_o, err_o, irq_o};
  endfunction

  // Caller is at the start of a cycle with the DUT idle; that cycle is cycle 0.
  task automatic run_txn(input vec_t v, input bit pulse, input string tag);
    int first = -1, last = -1, done_at = -1, idle_at = -1, done_cnt = 0;
    bit str_ok = 1'b1, bus_ok = 1'b1, act;
    logic sel_low, oth_low, err_done = 1'b0;
    logic [15:0] rd_done = 16'hxxxx;
    we_i = v.we; csel_i = v.csel; addr_i = v.addr; wdata_i = v.wdata;
    req_i = 1'b1;
    ide.iordy = (0 >= v.rise);
    ide.dd_in = 16'hDEAD;
    for (int n = 1; n <= 60; n++) begin
      tick();
      req_i = pulse && (n == 5 || n == 12);
      ide.iordy = (n >= v.rise);
      ide.dd_in = (n == v.exp_last) ? v.dd_in : 16'hDEAD;
      sel_low = v.we ? !ide.diow_ : !ide.dior_;
      oth_low = v.we ? !ide.dior_ : !ide.diow_;
      if (sel_low) begin
        if (first < 0) first = n;
        last = n;
      end
      if (oth_low) str_ok = 1'b0;
      if (done_o) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n; rd_done = rdata_o; err_done = err_o;
        end
      end
      act = (done_at < 0);
      if (ide.cs1fx_ !== !(act && !v.csel)) bus_ok = 1'b0;
      if (ide.cs3fx_ !== !(act && v.csel)) bus_ok = 1'b0;
      if (ide.da !== (act ? v.addr : 3'd0)) bus_ok = 1'b0;
      if (ide.dd_oe !== (act && v.we)) bus_ok = 1'b0;
      if (act && v.we && ide.dd_out !== v.wdata) bus_ok = 1'b0;
      if (!busy_o) begin
        idle_at = n;
        break;
      end
    end
    if (idle_at < 0) check({tag, "_idle_bound"}, 0, 1);
    check({tag, "_strobe_first"}, first, v.exp_first);
    check({tag, "_strobe_last"}, last, v.exp_last);
    check({tag, "_done_cycle"}, done_at, v.exp_done);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_idle_cycle"}, idle_at, v.exp_idle);
    check({tag, "_other_strobe"}, str_ok, 1);
    check({tag, "_bus_da_cs_dd"}, bus_ok, 1);
    if (!v.we) model_rdata = v.exp_rdata;
    check({tag, "_rdata"}, rd_done, model_rdata);
    check({tag, "_err"}, err_done, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    bit idle_ok, cs14, cs15;
    logic [43:0] pat;
    vec_t v;

    tbl.push_back('{1'b1, 1'b0, 3'd7, 16'h00A0, 16'h0000, 0, 3, 8, 10, 14, 16'h0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd6, 16'h0000, 16'h1234, 0, 3, 8, 10, 14, 16'h1234, 1'b0});
`ifdef IDE_HOST_IORDY_TMO_EN
    tbl.push_back('{1'b0, 1'b0, 3'd4, 16'h0000, 16'h1111, 1000, 3, 12, 14, 18, 16'hFFFF, 1'b1});
`else
    tbl.push_back('{1'b0, 1'b0, 3'd1, 16'h0000, 16'h5A5A, 12, 3, 14, 16, 20, 16'h5A5A, 1'b0});
`endif
    tbl.push_back('{1'b1, 1'b1, 3'd2, 16'hBEEF, 16'h0000, 7, 3, 9, 11, 15, 16'h0000, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd5, 16'h0000, 16'hC3C3, 3, 3, 8, 10, 14, 16'hC3C3, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 16'hFFFF, 16'h0000, 0, 3, 8, 10, 14, 16'h0000, 1'b0});

    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; csel_i = 1'b0; addr_i = 3'd0; wdata_i = 16'h0;
    ide.dd_in = 16'h0; ide.iordy = 1'b1; ide.intrq = 1'b0;
    model_rdata = 16'h0000;
    repeat (3) tick();
    check("reset_values", out_pat(), RST_PAT);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) run_txn(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // req pulses while busy must be dropped, not queued
    run_txn(tbl[0], 1'b1, "ignored_req");
    idle_ok = 1'b1;
    repeat (3) begin
      tick();
      if (busy_o) idle_ok = 1'b0;
    end
    check("ignored_req_no_restart", idle_ok, 1);

    // req held high restarts in the first idle cycle
    we_i = 1'b1; csel_i = 1'b0; addr_i = 3'd3; wdata_i = 16'h5555; req_i = 1'b1;
    ide.iordy = 1'b1;
    cs14 = 1'b0; cs15 = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n == 14) cs14 = ide.cs1fx_;
      if (n == 15) begin
        cs15 = ide.cs1fx_;
        req_i = 1'b0;
      end
    end
    check("held_req_cs_c14", cs14, 1);
    check("held_req_cs_c15", cs15, 0);
    idle_ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (!busy_o) begin
        idle_ok = 1'b1;
        break;
      end
    end
    check("held_req_second_done", idle_ok, 1);

    // reset in the middle of a read
    we_i = 1'b0; csel_i = 1'b1; addr_i = 3'd6; req_i = 1'b1;
    dcnt = 0;
    pat = '0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      req_i = 1'b0;
      if (n == 5) rst = 1'b1;
      if (n == 6) begin
        pat = out_pat();
        rst = 1'b0;
      end
      if (n >= 6 && done_o) dcnt++;
    end
    check("midrst_outputs", pat, RST_PAT);
    check("midrst_no_done", dcnt, 0);
    model_rdata = 16'h0000;
    v = tbl[0];
    run_txn(v, 1'b0, "post_rst");

    // interrupt synchroniser latency
    ide.intrq = 1'b1;
    tick();
    check("irq_c1", irq_o, 0);
    tick();
    check("irq_c2", irq_o, 1);
    ide.intrq = 1'b0;
    tick();
    tick();
    check("irq_clear", irq_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ide_host_pio.md
Name: ide_host_pio

Overview:
- PIO-mode ATA/IDE host (initiator) engine: the host-side counterpart of the device-side IDE interface block.
- Executes one 16-bit task-file register read or write per request.
- Drives DA/CS/DIOR-/DIOW- with programmable timing, honours IORDY and synchronises INTRQ.
- Used for bench/loopback testing of the GD-ROM emulator and as an on-chip master for drive bring-up.

Parameters:
- T1_CYC, 2, address/CS setup cycles before strobe (min 1)
- T2_CYC, 6, minimum strobe-low cycles (min 1)
- T4_CYC, 1, address/data hold cycles after strobe release (min 1)
- TREC_CYC, 4, recovery cycles after a cycle before the next request is accepted (min 1)
- IORDY_TMO, 256, max IORDY-extension cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  1  start request, sampled only while busy=0
- we  in  1  1=register write, 0=read
- csel  in  1  0=command block (cs1fx_), 1=control block (cs3fx_)
- addr  in  3  register address
- wdata  in  16  write data
- rdata  out  16  read data, valid from the done cycle until next accepted read
- done  out  1  one-cycle completion pulse
- busy  out  1  cycle in progress
- err  out  1  IORDY timeout flag (optional feature)
- dd_in  in  16  IDE data bus input
- dd_out  out  16  IDE data bus output
- dd_oe  out  1  IDE data bus output enable
- da  out  3  IDE address
- cs1fx_  out  1  chip select 0, active low
- cs3fx_  out  1  chip select 1, active low
- dior_  out  1  read strobe, active low
- diow_  out  1  write strobe, active low
- iordy  in  1  device ready, asynchronous
- intrq  in  1  device interrupt, asynchronous
- irq  out  1  intrq after a 2-flop synchroniser

Behaviour:
Reset values (synchronous reset):
- dior_=diow_=cs1fx_=cs3fx_=1
- da=0, dd_out=0, dd_oe=0, rdata=0
- done=0, busy=0, err=0, irq=0
- FSM returns to IDLE

FSM states and transitions:
- IDLE: when req=1 at an edge (call it cycle 0), latch we, csel, addr and wdata. From cycle 1: busy=1, da and selected cs_ driven. For writes, dd_out=wdata and dd_oe=1. Next state is SETUP.
- SETUP: lasts T1_CYC cycles (cycles 1..T1), then STROBE.
- STROBE: dior_ (read) or diow_ (write) low starting in cycle T1+1 and held for at least T2_CYC cycles. iordy passes through a 2-flop synchroniser (iordy_s). The strobe ends after the first strobe cycle n ≥ T2_CYC in which iordy_s=1; otherwise the strobe is extended. A read samples dd_in into rdata in the last strobe-low cycle.
- HOLD: strobe high for T4_CYC cycles; da, cs_, dd_out and dd_oe are unchanged.
- RECOVER:
  - In the first RECOVER cycle: done=1 for one cycle, cs_ deasserted, da=0, dd_oe=0.
  - Lasts TREC_CYC cycles; busy drops after the last one and the FSM returns to IDLE.
- Default latency with no IORDY extension: done in cycle T1+T2+T4+1 (10); busy=0 in cycle T1+T2+T4+TREC+1 (14).

Boundary conditions:
- req while busy=1 is ignored, not queued. req held high starts a new cycle in the first IDLE cycle.
- Strobes are never both low. cs1fx_ and cs3fx_ are never both low.
- Reset mid-cycle forces reset values on the next edge, with no done pulse.
- Counters are sized for the larger of T2_CYC and IORDY_TMO.

Optional Feature:
- IDE_HOST_IORDY_TMO_EN defined:
  - A strobe extended IORDY_TMO cycles beyond T2_CYC is terminated forcibly.
  - A read returns rdata=16'hFFFF; a write is simply ended.
  - err is set in the done cycle and holds until the next accepted req clears it.
- Not defined: the host waits for IORDY indefinitely and err is tied to 0.

Test Plan:
- Write, defaults, iordy=1, req at cycle 0 with we=1, csel=0, addr=7, wdata=0x00A0 -> cs1fx_=0 and da=7 for cycles 1-9; diow_=0 exactly cycles 3-8; dd_oe=1 with dd_out=0x00A0 for cycles 1-9; done at cycle 10; busy=0 at cycle 14.
- Read with csel=1, addr=6, dd_in=0x1234 -> cs3fx_=0, dior_=0 for cycles 3-8, rdata=0x1234 at done (cycle 10), dd_oe stays 0.
- iordy=0 from before req, raised at cycle 12 -> dior_ low cycles 3-14, done at cycle 16, data sampled in cycle 14.
- req pulsed again in cycles 5 and 12 -> ignored, exactly one done; req held high -> second cycle's cs asserted in cycle 15.
- rst asserted in cycle 5 -> next cycle all outputs at reset values, no done; req after release gives normal timing.
- IDE_HOST_IORDY_TMO_EN with IORDY_TMO=4 and iordy stuck 0 on a read -> dior_ low for cycles 3-12, done at cycle 14 with err=1 and rdata=0xFFFF; the next req clears err.
